// File: rtl/demux_1to2_seq.sv
// demux_1to2_seq: registered 1-to-2 stream demux with per-lane FIFOs and saturating beat counters
module demux_1to2_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sel,
  input  logic             auto_mode,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  localparam int AW = $clog2(DEPTH);
  logic                  rr_ptr, tgt, acc;
  logic [1:0]            full, vld, rdy;
  logic [1:0][WIDTH-1:0] dat;
  logic [1:0][CNT_W-1:0] beats;
  assign tgt = auto_mode ? rr_ptr : in_sel;
  assign in_ready = !full[tgt];
  assign acc = in_valid && in_ready;
  assign rdy = {out1_ready, out0_ready};
  assign out0_data = dat[0];
  assign out1_data = dat[1];
  assign out0_valid = vld[0];
  assign out1_valid = vld[1];
  assign cnt0 = beats[0];
  assign cnt1 = beats[1];
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_ptr <= 1'b0;
    else rr_ptr <= auto_mode ? rr_ptr ^ acc : 1'b0;
  for (genvar l = 0; l < 2; l++) begin : lane
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp, rp_n;
    logic [AW:0]      occ, occ_n;
    logic [WIDTH-1:0] head;
    logic [CNT_W-1:0] bc;
    logic             push, pop;
    assign push = acc && (tgt == 1'(l));
    assign pop = vld[l] && rdy[l];
    assign rp_n = rp + AW'(pop);
    assign occ_n = occ + (AW+1)'(push) - (AW+1)'(pop);
    assign full[l] = occ == (AW+1)'(DEPTH);
    assign vld[l] = occ != '0;
    assign dat[l] = head;
    assign beats[l] = bc;
    always_ff @(posedge clk)
      if (push) mem[wp] <= in_data;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        wp   <= '0;
        rp   <= '0;
        occ  <= '0;
        head <= '0;
        bc   <= '0;
      end else begin
        wp  <= wp + AW'(push);
        rp  <= rp_n;
        occ <= occ_n;
        // a beat written this cycle becomes head only when nothing older remains
        if (occ_n != '0) head <= (push && rp_n == wp) ? in_data : mem[rp_n];
        if (push && bc != '1) bc <= bc + 1'b1;
      end
  end
endmodule
